// File: rtl/sine_seq_pkg.sv
// Shared constants for the sine voice sequencer: FSM state encoding and
// configuration register addresses.
package sine_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ADDR_EN    = 4'd8;
    localparam logic [3:0] ADDR_PCLR  = 4'd9;
    localparam logic [3:0] ADDR_OVCLR = 4'd10;

endpackage

// File: rtl/sine_lookup.sv
// 256-point signed sine lookup, sampled at half-step offsets so that the table
// is exactly quarter-wave symmetric; only the first quadrant is stored.
module sine_lookup (
    input  logic [7:0]        i_index,
    output logic signed [7:0] o_value
);

    // trunc(127 * sin(2*pi*(k + 0.5) / 256)) for k = 0..63
    localparam logic [6:0] QTAB [64] = '{
        7'd1,   7'd4,   7'd7,   7'd10,  7'd13,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd52,  7'd55,  7'd58,  7'd61,  7'd63,  7'd66,  7'd69,
        7'd71,  7'd74,  7'd76,  7'd79,  7'd81,  7'd84,  7'd86,  7'd88,
        7'd90,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd102, 7'd104,
        7'd106, 7'd108, 7'd109, 7'd111, 7'd112, 7'd114, 7'd115, 7'd116,
        7'd117, 7'd119, 7'd120, 7'd121, 7'd121, 7'd122, 7'd123, 7'd124,
        7'd124, 7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126
    };

    logic [5:0]        w_qidx;
    logic signed [7:0] w_mag;

    always_comb begin
        w_qidx  = i_index[6] ? ~i_index[5:0] : i_index[5:0];
        w_mag   = $signed({1'b0, QTAB[w_qidx]});
        o_value = i_index[7] ? -w_mag : w_mag;
    end

endmodule

// File: rtl/sine_voice_sequencer.sv
// Time-multiplexed sine voice mixer: one voice per cycle through a shared lookup,
// averaged into an 8-bit signed sample per tick.
module sine_voice_sequencer
    import sine_seq_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_addr,
    input  logic [PHASE_W-1:0] cfg_data,
    output logic [7:0]         sample,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = 8 + IDX_W;

    state_t                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_idx, w_idx_nxt;
    logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [PHASE_W-1:0]      r_phase [NUM_VOICES];
    logic [PHASE_W-1:0]      r_freq  [NUM_VOICES];
    logic [NUM_VOICES-1:0]   r_en;
    logic [7:0]              r_sample;
    logic                    r_valid;
    logic                    r_overrun;

    logic [7:0]              w_lut_idx;
    logic signed [7:0]       w_lut_val;
    logic                    w_en_cur;
    logic [NUM_VOICES-1:0]   w_pclr;
    logic                    w_en_we;
    logic                    w_ov_set;
    logic                    w_ov_clr;

    assign w_lut_idx = r_phase[r_idx][PHASE_W-1 -: 8];
    assign w_en_cur  = r_en[r_idx];
    assign w_en_we   = cfg_we && (cfg_addr == ADDR_EN);
    assign w_pclr    = (cfg_we && (cfg_addr == ADDR_PCLR)) ? cfg_data[NUM_VOICES-1:0] : '0;
    assign w_ov_set  = tick && (r_state != IDLE);
    assign w_ov_clr  = cfg_we && (cfg_addr == ADDR_OVCLR);

    sine_lookup u_sine_lookup (
        .i_index (w_lut_idx),
        .o_value (w_lut_val)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        unique case (r_state)
            IDLE: begin
                if (tick) begin
                    w_state_nxt = RUN;
                    w_idx_nxt   = '0;
                    w_acc_nxt   = '0;
                end
            end
            RUN: begin
                if (w_en_cur) begin
                    w_acc_nxt = r_acc + {{IDX_W{w_lut_val[7]}}, w_lut_val};
                end
                if (r_idx == IDX_W'(NUM_VOICES - 1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_acc     <= '0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_acc   <= w_acc_nxt;
            r_valid <= (r_state == DONE);
            if (r_state == DONE) begin
                r_sample <= 8'(r_acc >>> IDX_W);
            end
            // A lost tick outranks a simultaneous clear request.
            if (w_ov_set) begin
                r_overrun <= 1'b1;
            end else if (w_ov_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_VOICES; n++) begin
                r_phase[n] <= '0;
                r_freq[n]  <= '0;
            end
            r_en <= '0;
        end else begin
            for (int n = 0; n < NUM_VOICES; n++) begin
                if (cfg_we && (cfg_addr == 4'(n))) begin
                    r_freq[n] <= cfg_data;
                end
                if (w_pclr[n]) begin
                    r_phase[n] <= '0;
                end else if ((r_state == RUN) && (r_idx == IDX_W'(n)) && r_en[n]) begin
                    r_phase[n] <= r_phase[n] + r_freq[n];
                end
            end
            if (w_en_we) begin
                r_en <= cfg_data[NUM_VOICES-1:0];
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign busy         = (r_state != IDLE);
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_sine_voice_sequencer.sv
// Directed bench for sine_voice_sequencer with hand-computed sample values
// (NUM_VOICES=4, PHASE_W=16).
module tb_sine_voice_sequencer;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    int vectors;
    int miscompares;
    int cyc;
    int pulses;

    sine_voice_sequencer #(
        .NUM_VOICES (4),
        .PHASE_W    (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // One tick, then bounded wait for sample_valid; latency counts from the tick edge.
    task automatic run_tick(input string tag, input logic [7:0] exp);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        cyc  = 1;
        check({tag, "_busy"}, 16'(busy), 16'd1);
        while (!sample_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 16'(cyc), 16'd6);
        check({tag, "_sample"}, 16'(sample), 16'(exp));
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 16'(sample_valid), 16'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        tick        = 1'b0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sample", 16'(sample), 16'h00);
        check("rst_valid", 16'(sample_valid), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_overrun", 16'(overrun), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All voices at lookup index 0 (value 1), then index 1 (value 4).
        for (int n = 0; n < 4; n++) cfg_write(4'(n), 16'h0100);
        cfg_write(4'd8, 16'h000F);
        run_tick("mix1", 8'h01);
        run_tick("mix2", 8'h04);

        // Half-cycle steps: index 0 (+1 each) then 0x80 (-1 each).
        cfg_write(4'd9, 16'h000F);
        for (int n = 0; n < 4; n++) cfg_write(4'(n), 16'h8000);
        run_tick("neg1", 8'h01);
        run_tick("neg2", 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        check("hold_sample", 16'(sample), 16'h00FF);

        // Only voice 0 enabled: sum 1 -> 0; disabled voices must not advance.
        cfg_write(4'd9, 16'h000F);
        cfg_write(4'd0, 16'h0100);
        cfg_write(4'd8, 16'h0001);
        run_tick("mask", 8'h00);
        // v0 at index 1 (4), v1..v3 still 0 (1 each): 7 >>> 2 = 1.
        cfg_write(4'd8, 16'h000F);
        run_tick("mask_phase", 8'h01);

        // Second tick two cycles later is lost. v0 idx 2 (7), others 0x80: 4 >>> 2 = 1.
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        @(posedge clk);
        #1;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        check("ovr_set", 16'(overrun), 16'd1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (sample_valid) begin
                pulses++;
                check("ovr_sample", 16'(sample), 16'h0001);
            end
            @(posedge clk);
            #1;
        end
        check("ovr_pulses", 16'(pulses), 16'd1);
        cfg_write(4'd10, 16'h0000);
        check("ovr_clear", 16'(overrun), 16'd0);

        // Lost tick and clear in the same cycle: overrun stays set.
        // v0 idx 3 (10), others idx 0 (1 each): 13 >>> 2 = 3.
        tick = 1'b1;
        @(posedge clk);
        #1;
        cfg_we   = 1'b1;
        cfg_addr = 4'd10;
        cfg_data = 16'h0000;
        @(posedge clk);
        #1;
        tick   = 1'b0;
        cfg_we = 1'b0;
        check("ovr_race", 16'(overrun), 16'd1);
        cyc = 2;
        while (!sample_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("ovr_race_latency", 16'(cyc), 16'd6);
        check("ovr_race_sample", 16'(sample), 16'h0003);

        // Reset three cycles into a sequence.
        @(posedge clk);
        #1;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 16'(busy), 16'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sample", 16'(sample), 16'h00);
        check("mid_rst_valid", 16'(sample_valid), 16'd0);
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_overrun", 16'(overrun), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (sample_valid) pulses++;
        end
        check("mid_no_pulse", 16'(pulses), 16'd0);
        for (int n = 0; n < 4; n++) cfg_write(4'(n), 16'h0100);
        cfg_write(4'd8, 16'h000F);
        run_tick("post_rst", 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
